// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_rx serial receiver.
package sipo_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  function automatic int unsigned count_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_hold.sv
// Single-entry holding register with valid/ready handshake and sticky overrun flag.
module sipo_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ovr_set;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (word_done) begin
      // A word arriving while the entry drains this cycle still fits.
      if (!valid_q || ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: frames WIDTH bits on sof and hands words to sipo_hold.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             busy
);

  localparam int unsigned     CountW    = count_w(WIDTH);
  localparam logic [CountW-1:0] LastCount = CountW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  first_bit, shifted;
  logic              word_done;

  assign first_bit = MSB_FIRST ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
  assign shifted   = MSB_FIRST ? {shift_q[WIDTH-2:0], sin} : {sin, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    if (sin_en) begin
      unique case (state_q)
        StIdle: begin
          if (sof) begin
            shift_d = first_bit;
            count_d = CountW'(1);
            state_d = StShift;
          end
        end
        StShift: begin
          // A fresh sof mid-frame silently abandons the partial word.
          if (sof) begin
            shift_d = first_bit;
            count_d = CountW'(1);
          end else begin
            shift_d = shifted;
            if (count_q == LastCount) begin
              count_d   = '0;
              state_d   = StIdle;
              word_done = 1'b1;
            end else begin
              count_d = count_q + CountW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

  assign busy = (state_q == StShift);

  sipo_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .word     (shift_d),
    .word_done(word_done),
    .ready    (ready),
    .clr_ovr  (clr_ovr),
    .data     (data),
    .valid    (valid),
    .overrun  (overrun)
  );

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver: the receive end of the team's PISO serial link. It collects WIDTH bits framed by a start-of-frame strobe and assembles them into a parallel word. Completed words go into a single-entry holding register with a valid/ready handshake to downstream logic. Overruns are flagged when a word completes while the holding register is still occupied.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32
- MSB_FIRST, 1, 1: first received bit lands in data[WIDTH-1]; 0: first received bit lands in data[0]

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sin  in  1  serial data, sampled when sin_en=1
- sin_en  in  1  bit strobe; one serial bit per cycle with sin_en=1
- sof  in  1  start of frame; qualified by sin_en; marks the cycle carrying the first bit of a word
- data  out  WIDTH  holding register contents; stable while valid=1
- valid  out  1  holding register occupied
- ready  in  1  downstream accept; a transfer occurs when valid=1 and ready=1
- overrun  out  1  sticky: a completed word was dropped
- clr_ovr  in  1  synchronous clear of overrun
- busy  out  1  frame in progress (state SHIFT)

## Operation
- FSM states: IDLE, SHIFT. busy = (state == SHIFT).
- IDLE:
  - sin_en & sof: load the first bit into the shift register, set count=1, go to SHIFT.
  - sin_en & !sof: bit discarded.
- SHIFT, on sin_en & !sof:
  - Shift in the bit and increment count.
  - When count == WIDTH-1 before the edge, the word is complete: go to IDLE with count=0.
- SHIFT, on sin_en & sof: abort the partial word (no output, no overrun) and restart with this bit as bit 0, count=1, staying in SHIFT.
- sin_en=0: no change to the shift register or count; gaps of any length are allowed mid-frame.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit into the LSB.
  - MSB_FIRST=0: shift right, new bit into the MSB.
- Word complete, holding register update:
  - Holding empty (valid=0), or valid & ready in the same cycle: data ← assembled word, valid=1.
  - valid & !ready: the new word is dropped, data keeps the old word, overrun ← 1.
- No completion and valid & ready: valid ← 0. data holds its last value.
- overrun: cleared by clr_ovr; if set and clr_ovr occur in the same cycle, set wins.

## Timing
- Reset values: state=IDLE, count=0, shift register=0, data=0, valid=0, overrun=0, busy=0.
- Reset is asynchronous and may assert mid-frame. The partial word is lost, and the next word requires a fresh sof.
- Latency: valid rises at the same clock edge that samples the final bit. Minimum time from the sof bit to valid is WIDTH edges with back-to-back sin_en.
- Throughput: one word per WIDTH cycles with continuous sin_en. The sof of the next word may immediately follow the last bit of the previous one, with no idle cycle required.
- ready is combinationally unused; outputs are registered only.
- Count width: COUNT_W = $clog2(WIDTH). count never reaches WIDTH.

## Structure
- Package sipo_pkg holds:
  - the state enum (IDLE, SHIFT)
  - a function count_w(WIDTH) returning $clog2(WIDTH)
- Sub-module sipo_hold: single-entry holding register with valid/ready and overrun logic. Its inputs are the word, a word_done pulse, ready and clr_ovr.
- Top level contains the FSM, counter and shift register.

## Test plan
- Reset, then sof+8 bits 0,1,1,0,1,0,0,1 back-to-back with MSB_FIRST=1 and ready=1 → valid pulses for one cycle with data=8'h69, overrun=0.
- Same bit stream with MSB_FIRST=0 → data=8'h96. Also insert 3-cycle sin_en gaps mid-frame → same result, and busy=1 throughout the gaps.
- Two back-to-back frames (8'h96 then 8'h69) with ready=0 → data stays 8'h96, valid=1, overrun=1. Then assert clr_ovr together with ready → overrun=0, valid=0.
- After 4 bits of a frame, assert sof with a new 8-bit frame of 8'hA5 → only 8'hA5 is delivered and no overrun occurs. Separately, assert rst_n=0 mid-frame → all outputs return to reset values and bits without sof are ignored afterwards.
- Word completes in the same cycle that ready accepts the previous word → the new word loads, valid stays 1, overrun=0.
- Loopback: a PISO loaded with 8'b01101001 drives sin, with sof on the first shifted bit → data=8'h69.
